// File: rtl/sdram_cmd_arbit.sv
// SDRAM command arbiter: sequences power-up init, then hands the shared
// command/address/data bus to refresh (highest priority), write or read,
// with round-robin between write and read when both are pending.
module sdram_cmd_arbit #(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned DATA_W  = 16,
  parameter logic [3:0]  NOP_CMD = 4'b0111
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [3:0]        init_cmd,
  input  logic [1:0]        init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              init_end,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [1:0]        aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [1:0]        wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [1:0]        rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [1:0]        sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  inout  wire  [DATA_W-1:0] sdram_dq
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_ARBIT = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_e;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_e;

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic              aref_en_q, aref_en_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic [3:0]        cmd_c;
  logic [1:0]        ba_c;
  logic [ADDR_W-1:0] addr_c;

  // State, last contested grant and grant enables
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_INIT;
      last_grant_q <= GNT_RD;
      aref_en_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      aref_en_q    <= aref_en_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
    end
  end

  // Next-state / grant decision; every grant passes back through ARBIT
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    aref_en_d    = aref_en_q;
    wr_en_d      = wr_en_q;
    rd_en_d      = rd_en_q;
    case (state_q)
      S_INIT: begin
        if (init_end) state_d = S_ARBIT;
      end
      S_ARBIT: begin
        if (aref_req) begin
          state_d   = S_AREF;
          aref_en_d = 1'b1;
        end else if (wr_req && rd_req) begin
          // Contested: the side that did not win last time gets the bus
          if (last_grant_q == GNT_RD) begin
            state_d      = S_WRITE;
            wr_en_d      = 1'b1;
            last_grant_d = GNT_WR;
          end else begin
            state_d      = S_READ;
            rd_en_d      = 1'b1;
            last_grant_d = GNT_RD;
          end
        end else if (wr_req) begin
          state_d = S_WRITE;
          wr_en_d = 1'b1;
        end else if (rd_req) begin
          state_d = S_READ;
          rd_en_d = 1'b1;
        end
      end
      S_AREF: begin
        if (aref_end) begin
          state_d   = S_ARBIT;
          aref_en_d = 1'b0;
        end
      end
      S_WRITE: begin
        if (wr_end) begin
          state_d = S_ARBIT;
          wr_en_d = 1'b0;
        end
      end
      S_READ: begin
        if (rd_end) begin
          state_d = S_ARBIT;
          rd_en_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_INIT;
        aref_en_d = 1'b0;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
      end
    endcase
  end

  // Command/bank/address mux selected by the current owner
  always_comb begin
    cmd_c  = NOP_CMD;
    ba_c   = 2'b11;
    addr_c = '1;
    case (state_q)
      S_INIT: begin
        cmd_c  = init_cmd;
        ba_c   = init_ba;
        addr_c = init_addr;
      end
      S_AREF: begin
        cmd_c  = aref_cmd;
        ba_c   = aref_ba;
        addr_c = aref_addr;
      end
      S_WRITE: begin
        cmd_c  = wr_cmd;
        ba_c   = wr_ba;
        addr_c = wr_addr;
      end
      S_READ: begin
        cmd_c  = rd_cmd;
        ba_c   = rd_ba;
        addr_c = rd_addr;
      end
      default: begin
        cmd_c  = NOP_CMD;
        ba_c   = 2'b11;
        addr_c = '1;
      end
    endcase
  end

  assign aref_en   = aref_en_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign sdram_cke = 1'b1;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_c;
  assign sdram_ba   = ba_c;
  assign sdram_addr = addr_c;

  // DQ is only driven by the write owner while it enables its data
  assign sdram_dq = (wr_sdram_en && (state_q == S_WRITE)) ? wr_sdram_data
                                                          : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sdram_cmd_arbit.sv
// Directed bench for sdram_cmd_arbit: init sequencing, round-robin,
// refresh priority, DQ tri-state and mid-burst reset.
module tb_sdram_cmd_arbit;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 16;

  localparam logic [3:0] INIT_CMD = 4'b0010;
  localparam logic [3:0] AREF_CMD = 4'b0001;
  localparam logic [3:0] WR_CMD   = 4'b0100;
  localparam logic [3:0] RD_CMD   = 4'b0101;
  localparam logic [3:0] NOP      = 4'b0111;

  localparam logic [1:0]        INIT_BA   = 2'b00;
  localparam logic [1:0]        AREF_BA   = 2'b01;
  localparam logic [1:0]        WR_BA     = 2'b10;
  localparam logic [1:0]        RD_BA     = 2'b01;
  localparam logic [ADDR_W-1:0] INIT_ADDR = 13'h0400;
  localparam logic [ADDR_W-1:0] AREF_ADDR = 13'h0101;
  localparam logic [ADDR_W-1:0] WR_ADDR   = 13'h0222;
  localparam logic [ADDR_W-1:0] RD_ADDR   = 13'h0333;

  logic clk, rst_n;
  logic init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
  logic wr_sdram_en;
  logic [DATA_W-1:0] wr_sdram_data;
  logic aref_en, wr_en, rd_en, cke, cs_n, ras_n, cas_n, we_n;
  logic [1:0] ba;
  logic [ADDR_W-1:0] addr;
  wire  [DATA_W-1:0] dq;

  int n_chk  = 0;
  int n_fail = 0;
  int oh_viol = 0;

  sdram_cmd_arbit dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .init_cmd(INIT_CMD), .init_ba(INIT_BA), .init_addr(INIT_ADDR), .init_end(init_end),
    .aref_req(aref_req), .aref_end(aref_end),
    .aref_cmd(AREF_CMD), .aref_ba(AREF_BA), .aref_addr(AREF_ADDR),
    .wr_req(wr_req), .wr_end(wr_end),
    .wr_cmd(WR_CMD), .wr_ba(WR_BA), .wr_addr(WR_ADDR),
    .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .rd_req(rd_req), .rd_end(rd_end),
    .rd_cmd(RD_CMD), .rd_ba(RD_BA), .rd_addr(RD_ADDR),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cke(cke), .sdram_cs_n(cs_n), .sdram_ras_n(ras_n),
    .sdram_cas_n(cas_n), .sdram_we_n(we_n),
    .sdram_ba(ba), .sdram_addr(addr), .sdram_dq(dq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grants must be mutually exclusive at all times out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      assert ($onehot0({aref_en, wr_en, rd_en}))
      else begin
        oh_viol++;
        $display("FAIL onehot_grant: aref_en=%0b wr_en=%0b rd_en=%0b", aref_en, wr_en, rd_en);
      end
    end
  end

  typedef struct {
    logic [5:0] in;   // {aref_req, wr_req, rd_req, aref_end, wr_end, rd_end}
    logic [2:0] ex;   // {aref_en, wr_en, rd_en}
    logic [3:0] cmd;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mkv(input logic [5:0] in, input logic [2:0] ex, input logic [3:0] cmd);
    vec_t v;
    v.in  = in;
    v.ex  = ex;
    v.cmd = cmd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Checks grants plus the full command/bank/address bus for an owner
  task automatic chk_state(input string name, input logic [2:0] ex, input logic [3:0] cmd);
    logic [1:0]        eba;
    logic [ADDR_W-1:0] eaddr;
    case (cmd)
      INIT_CMD: begin eba = INIT_BA; eaddr = INIT_ADDR; end
      AREF_CMD: begin eba = AREF_BA; eaddr = AREF_ADDR; end
      WR_CMD:   begin eba = WR_BA;   eaddr = WR_ADDR;   end
      RD_CMD:   begin eba = RD_BA;   eaddr = RD_ADDR;   end
      default:  begin eba = 2'b11;   eaddr = '1;        end
    endcase
    chk({name, ".grant"}, 32'({aref_en, wr_en, rd_en}), 32'(ex));
    chk({name, ".bus"}, 32'({cs_n, ras_n, cas_n, we_n, ba, addr}), 32'({cmd, eba, eaddr}));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic [5:0] in);
    {aref_req, wr_req, rd_req, aref_end, wr_end, rd_end} = in;
  endtask

  initial begin
    vecs[0]  = mkv(6'b110000, 3'b100, AREF_CMD);
    vecs[1]  = mkv(6'b010000, 3'b100, AREF_CMD);
    vecs[2]  = mkv(6'b010100, 3'b000, NOP);
    vecs[3]  = mkv(6'b010000, 3'b010, WR_CMD);
    vecs[4]  = mkv(6'b001101, 3'b010, WR_CMD);
    vecs[5]  = mkv(6'b001010, 3'b000, NOP);
    vecs[6]  = mkv(6'b001000, 3'b001, RD_CMD);
    vecs[7]  = mkv(6'b001010, 3'b001, RD_CMD);
    vecs[8]  = mkv(6'b000001, 3'b000, NOP);
    vecs[9]  = mkv(6'b000000, 3'b000, NOP);
    vecs[10] = mkv(6'b011000, 3'b010, WR_CMD);
    vecs[11] = mkv(6'b000010, 3'b000, NOP);
    vecs[12] = mkv(6'b001000, 3'b001, RD_CMD);
    vecs[13] = mkv(6'b000001, 3'b000, NOP);
    vecs[14] = mkv(6'b011000, 3'b001, RD_CMD);
    vecs[15] = mkv(6'b011001, 3'b000, NOP);
    vecs[16] = mkv(6'b011000, 3'b010, WR_CMD);
    vecs[17] = mkv(6'b000010, 3'b000, NOP);

    rst_n = 1'b0;
    init_end = 1'b0;
    set_in(6'b000000);
    wr_sdram_en = 1'b0;
    wr_sdram_data = '0;

    // Reset and init sequencing
    repeat (3) @(negedge clk);
    chk_state("in_reset", 3'b000, INIT_CMD);
    chk("cke", 32'(cke), 32'd1);
    rst_n = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      step();
      chk_state("init_hold", 3'b000, INIT_CMD);
    end
    init_end = 1'b1;
    step();
    chk_state("init_done_nop", 3'b000, NOP);
    step();
    chk_state("arbit_idle", 3'b000, NOP);

    // Round-robin with both requests held: W,R,W,R
    wr_req = 1'b1;
    rd_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      step();
      chk_state("rr_grant", (g % 2 == 0) ? 3'b010 : 3'b001, (g % 2 == 0) ? WR_CMD : RD_CMD);
      repeat (9) step();
      chk_state("rr_hold", (g % 2 == 0) ? 3'b010 : 3'b001, (g % 2 == 0) ? WR_CMD : RD_CMD);
      if (g % 2 == 0) wr_end = 1'b1; else rd_end = 1'b1;
      step();
      wr_end = 1'b0;
      rd_end = 1'b0;
      chk_state("rr_gap_nop", 3'b000, NOP);
    end
    wr_req = 1'b0;
    rd_req = 1'b0;

    // Table: priority, ignored pulses, single vs contested grants
    for (int i = 0; i < 18; i++) begin
      set_in(vecs[i].in);
      step();
      chk_state($sformatf("vec%0d", i), vecs[i].ex, vecs[i].cmd);
    end
    set_in(6'b000000);

    // DQ drive only in WRITE with data enable
    wr_req = 1'b1;
    wr_sdram_en = 1'b1;
    wr_sdram_data = 16'h00A5;
    step();
    wr_req = 1'b0;
    chk_state("dq_wr_grant", 3'b010, WR_CMD);
    chk("dq_driven", 32'(dq), 32'h0000_00A5);
    wr_sdram_en = 1'b0;
    #1;
    n_chk++;
    if (dq !== 16'hzzzz) begin n_fail++; $display("FAIL dq_wr_noen: got %0h expected z", dq); end
    @(negedge clk);
    wr_end = 1'b1;
    step();
    wr_end = 1'b0;
    rd_req = 1'b1;
    wr_sdram_en = 1'b1;
    step();
    rd_req = 1'b0;
    chk_state("dq_rd_grant", 3'b001, RD_CMD);
    n_chk++;
    if (dq !== 16'hzzzz) begin n_fail++; $display("FAIL dq_read: got %0h expected z", dq); end
    rd_end = 1'b1;
    step();
    rd_end = 1'b0;
    wr_sdram_en = 1'b0;
    chk_state("dq_done_nop", 3'b000, NOP);

    // Refresh raised mid-write waits for wr_end, then beats pending read
    wr_req = 1'b1;
    step();
    chk_state("nopre_wr", 3'b010, WR_CMD);
    wr_req = 1'b0;
    aref_req = 1'b1;
    rd_req = 1'b1;
    step();
    step();
    chk_state("nopre_hold", 3'b010, WR_CMD);
    wr_end = 1'b1;
    step();
    wr_end = 1'b0;
    chk_state("nopre_nop", 3'b000, NOP);
    step();
    chk_state("nopre_aref", 3'b100, AREF_CMD);
    aref_req = 1'b0;
    aref_end = 1'b1;
    step();
    aref_end = 1'b0;
    chk_state("aref_end_nop", 3'b000, NOP);
    step();
    chk_state("rd_after_aref", 3'b001, RD_CMD);
    step();
    chk_state("rd_hold", 3'b001, RD_CMD);

    // Reset mid-read: immediate INIT, no grant until init_end again
    rst_n = 1'b0;
    init_end = 1'b0;
    #1;
    chk_state("rst_midread", 3'b000, INIT_CMD);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk_state("reinit_wait", 3'b000, INIT_CMD);
    end
    init_end = 1'b1;
    step();
    chk_state("reinit_nop", 3'b000, NOP);
    step();
    chk_state("reinit_rd", 3'b001, RD_CMD);
    rd_req = 1'b0;
    rd_end = 1'b1;
    step();
    rd_end = 1'b0;
    chk_state("final_nop", 3'b000, NOP);

    chk("onehot_violations", 32'(oh_viol), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_cmd_arbit.md
Name: sdram_cmd_arbit

Overview:
- Sits inside the SDRAM controller, between the init, auto-refresh, write and read command generators and the SDRAM pins.
- Sequences power-up init, then grants the single SDRAM command/address/data bus to one requester at a time.
- Priority: auto-refresh is always highest. Write and read share the bus round-robin when both are pending.
- Drives the muxed command, bank and address outputs and the tri-state DQ.

Parameters:
- ADDR_W, 13, SDRAM address width.
- DATA_W, 16, SDRAM DQ width.
- NOP_CMD, 4'b0111, {cs_n,ras_n,cas_n,we_n} value driven while arbitrating.

Ports:
- sys_clk  in  1  controller clock (100 MHz).
- sys_rst_n  in  1  asynchronous active-low reset.
- init_cmd  in  4  init command {cs_n,ras_n,cas_n,we_n}.
- init_ba  in  2  init bank.
- init_addr  in  ADDR_W  init address.
- init_end  in  1  init complete; level, stays high once set.
- aref_req  in  1  refresh request; level.
- aref_end  in  1  refresh done; 1-cycle pulse.
- aref_cmd / aref_ba / aref_addr  in  4/2/ADDR_W  refresh command bus.
- wr_req  in  1  write request; level.
- wr_end  in  1  write burst done; 1-cycle pulse.
- wr_cmd / wr_ba / wr_addr  in  4/2/ADDR_W  write command bus.
- wr_sdram_en  in  1  write data drive enable.
- wr_sdram_data  in  DATA_W  write data.
- rd_req  in  1  read request; level.
- rd_end  in  1  read burst done; 1-cycle pulse.
- rd_cmd / rd_ba / rd_addr  in  4/2/ADDR_W  read command bus.
- aref_en  out  1  refresh grant.
- wr_en  out  1  write grant.
- rd_en  out  1  read grant.
- sdram_cke  out  1  clock enable, constant 1.
- sdram_cs_n / sdram_ras_n / sdram_cas_n / sdram_we_n  out  1 each  command bits.
- sdram_ba  out  2  bank.
- sdram_addr  out  ADDR_W  address.
- sdram_dq  inout  DATA_W  data bus.

Behaviour:
- Reset values: state=INIT; aref_en=wr_en=rd_en=0; last_grant=READ, so the first write/read contest grants write; sdram_cke=1.
- During reset, the command outputs follow the init bus.
- States: INIT, ARBIT, AREF, WRITE, READ. All are registered on sys_clk.
- INIT: outputs = init_cmd/init_ba/init_addr. When init_end=1 at an edge, go to ARBIT on the next cycle.
- ARBIT: outputs = NOP_CMD, ba=2'b11, addr=all ones. At each edge, decide in this order:
  - aref_req=1 -> go to AREF and set aref_en<=1 on the same edge.
  - else wr_req and rd_req both 1 -> grant the one not equal to last_grant, update last_grant, and set its enable.
  - else wr_req only -> go to WRITE, wr_en<=1.
  - else rd_req only -> go to READ, rd_en<=1.
  - else stay in ARBIT.
- Grant latency: request seen at edge N -> enable high and state changed after edge N. The owner's command appears on the pins in cycle N+1.
- AREF / WRITE / READ: outputs = the owner's cmd/ba/addr, combinational mux on state.
  - When the owner's *_end=1 at an edge, clear its enable and return to ARBIT on the same edge.
  - At least one ARBIT (NOP) cycle always separates two grants.
- No preemption: aref_req arriving during WRITE/READ waits. The write/read generators shorten their burst on aref_req, which is outside this block. Refresh is granted at the first ARBIT cycle after the end pulse.
- *_end pulses in a non-matching state are ignored. *_req while that requester is already granted is ignored.
- A single request does not update last_grant. Only a contested grant does.
- sdram_dq = wr_sdram_data when wr_sdram_en=1 and state=WRITE; otherwise high-Z.
- The command outputs are split directly: {cs_n,ras_n,cas_n,we_n} = the selected 4-bit cmd.
- Reset asserted mid-burst: immediately return to INIT and clear all enables. The bus reverts to init, and a fresh init_end is required.
- At most one of aref_en/wr_en/rd_en is ever high; the bench checks this with an assertion.

Test Plan:
- Reset released, init_cmd=4'b0010, init_end rises at cycle 20 -> pins show 0010 through cycle 20, NOP 0111 from cycle 21, all enables 0.
- In ARBIT, aref_req and wr_req both high -> aref_en=1 next cycle with wr_en=0. aref_end pulse -> one NOP cycle, then wr_en=1.
- wr_req and rd_req held high continuously, end pulses 10 cycles after each grant -> grants alternate W,R,W,R (first W). Exactly one NOP cycle between grants.
- WRITE granted, wr_sdram_en=1, data=16'h00A5 -> sdram_dq reads 00A5. wr_sdram_en=0 -> dq=Z. Same data during READ -> dq=Z.
- aref_req raised mid-WRITE -> wr_en stays 1 until wr_end. aref_en=1 at the first ARBIT edge after that, even with rd_req pending.
- sys_rst_n pulsed low mid-READ -> rd_en=0 immediately and state INIT. No grant until init_end is reasserted.
